conv_writeback_ctrl: RTL and testbench

Parametrised write-back controller for the conv kernel. It sequences buffer init, conv start and per-row-group partial-sum drain for NUM_ROWS accumulator rows onto NUM_PORTS output ports. Compared with the fixed 5-row/2-port generation, it adds output backpressure (out_ready), a generic row-group schedule, a busy flag and illegal-pattern error reporting. It sits between the row accumulators/line buffers and the output memory writer.

---
 rtl/conv_wb_pkg.sv | 47 ++++
 rtl/conv_wb_port_mux.sv | 78 +++++++
 rtl/conv_writeback_ctrl.sv | 158 +++++++++++++++
 tb/tb_conv_writeback_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_wb_pkg.sv
// Shared types and helpers for the conv write-back controller.
//   wb_state_e : controller state encoding (4-bit)
//   clog2      : ceil(log2(v)); 0 for v <= 1
//   clog2_min1 : clog2 with a floor of 1 (for register widths)
//   grp_mask   : row mask of drain group g, given ports per group and row count
package conv_wb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_INIT_BUFF   = 4'd1,
        ST_START_CONV  = 4'd2,
        ST_WAIT_FILTER = 4'd3,
        ST_WAIT_ADD    = 4'd4,
        ST_DRAIN       = 4'd5,
        ST_GAP         = 4'd6
    } wb_state_e;

    localparam int unsigned MASK_W = 32;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = clog2(v);
        return (r == 0) ? 1 : r;
    endfunction

    // Group g covers rows g*nports .. min((g+1)*nports, nrows)-1.
    function automatic logic [MASK_W-1:0] grp_mask(input int unsigned g,
                                                   input int unsigned nports,
                                                   input int unsigned nrows);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int unsigned r = 0; r < MASK_W; r++) begin
            if (r >= g * nports && r < (g + 1) * nports && r < nrows) m[r] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/conv_wb_port_mux.sv
// Registered row-group to output-port mux.
//   clk, rst_n   : clock, asynchronous active-low reset
//   row_data_i   : NUM_ROWS samples, row r at [r*DATA_W +: DATA_W]
//   row_valid_i  : per-row valid; must equal exactly one group mask or zero
//   out_ready_i  : downstream accepts all ports this cycle
//   out_data_o   : NUM_PORTS samples, port p at [p*DATA_W +: DATA_W]
//   out_valid_o  : per-port valid
//   err_mux_o    : one-cycle pulse when row_valid_i matches no group
module conv_wb_port_mux
    import conv_wb_pkg::*;
#(
    parameter int unsigned DATA_W    = 25,
    parameter int unsigned NUM_ROWS  = 5,
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_ROWS*DATA_W-1:0]    row_data_i,
    input  logic [NUM_ROWS-1:0]           row_valid_i,
    input  logic                          out_ready_i,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data_o,
    output logic [NUM_PORTS-1:0]          out_valid_o,
    output logic                          err_mux_o
);

    localparam int unsigned NUM_GRP = (NUM_ROWS + NUM_PORTS - 1) / NUM_PORTS;

    logic [NUM_PORTS*DATA_W-1:0] data_q, data_d;
    logic [NUM_PORTS-1:0]        valid_q, valid_d;
    logic                        err_q, err_d;
    logic                        hit;

    always_comb begin
        data_d  = '0;
        valid_d = '0;
        err_d   = 1'b0;
        hit     = 1'b0;
        if (valid_q != '0 && !out_ready_i) begin
            // Stalled with data pending: keep presenting it.
            data_d  = data_q;
            valid_d = valid_q;
        end else begin
            for (int unsigned g = 0; g < NUM_GRP; g++) begin
                if (row_valid_i == NUM_ROWS'(grp_mask(g, NUM_PORTS, NUM_ROWS))) begin
                    hit = 1'b1;
                    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                        // Select index is clamped so the short last group never
                        // forms an out-of-range slice; those ports stay 0/0.
                        if (g * NUM_PORTS + p < NUM_ROWS) begin
                            data_d[p*DATA_W +: DATA_W] =
                                row_data_i[((g * NUM_PORTS + p < NUM_ROWS) ?
                                            (g * NUM_PORTS + p) : 0) * DATA_W +: DATA_W];
                            valid_d[p] = 1'b1;
                        end
                    end
                end
            end
            if (!hit && row_valid_i != '0) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
    assign err_mux_o   = err_q;

endmodule

// File: rtl/conv_writeback_ctrl.sv
// Write-back controller for the conv kernel: buffer init, conv start and
// per-row-group partial-sum drain of NUM_ROWS rows onto NUM_PORTS ports.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_init  : starts a frame from IDLE
//   filter_end  : all filters of the current row band accumulated
//   row_data    : row samples, row r at [r*DATA_W +: DATA_W]
//   row_valid   : per-row sample valid
//   row_ready   : combinational, row r may advance
//   write_zero  : registered, row r buffer read-cleared
//   init        : registered, push zero into empty buffers
//   start_conv  : registered conv enable
//   out_data    : port samples, port p at [p*DATA_W +: DATA_W]
//   out_valid   : per-port valid
//   out_ready   : downstream accepts all ports
//   busy        : registered, controller not idle
//   err_mux     : registered pulse on an illegal row_valid pattern
module conv_writeback_ctrl
    import conv_wb_pkg::*;
#(
    parameter int unsigned DATA_W    = 25,
    parameter int unsigned DEPTH     = 61,
    parameter int unsigned NUM_ROWS  = 5,
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned CONV_TAIL = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_init,
    input  logic                          filter_end,
    input  logic [NUM_ROWS*DATA_W-1:0]    row_data,
    input  logic [NUM_ROWS-1:0]           row_valid,
    output logic [NUM_ROWS-1:0]           row_ready,
    output logic [NUM_ROWS-1:0]           write_zero,
    output logic                          init,
    output logic                          start_conv,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic [NUM_PORTS-1:0]          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          err_mux
);

    localparam int unsigned NUM_GRP = (NUM_ROWS + NUM_PORTS - 1) / NUM_PORTS;
    localparam int unsigned CNT_W   = clog2_min1(DEPTH + CONV_TAIL + 1);
    localparam int unsigned GRP_W   = clog2_min1(NUM_GRP);

    localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DEPTH + CONV_TAIL - 1);
    localparam logic [GRP_W-1:0] LAST_G = GRP_W'(NUM_GRP - 1);

    wb_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GRP_W-1:0]     grp_q, grp_d;
    logic [NUM_ROWS-1:0]  grp_rows;
    logic [NUM_ROWS-1:0]  row_ready_w;
    logic [NUM_ROWS-1:0]  write_zero_q;
    logic                 init_q, start_conv_q, busy_q;

    assign grp_rows    = NUM_ROWS'(grp_mask(32'(grp_q), NUM_PORTS, NUM_ROWS));
    assign row_ready_w = (state_q == ST_DRAIN && out_ready) ? grp_rows : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        grp_d   = grp_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_init) state_d = ST_INIT_BUFF;
            end
            ST_INIT_BUFF: begin
                if (cnt_q == LAST_D) begin
                    state_d = ST_START_CONV;
                    cnt_d   = '0;
                end
            end
            ST_START_CONV: begin
                if (cnt_q == LAST_C) begin
                    state_d = ST_WAIT_FILTER;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_FILTER: begin
                if (filter_end) begin
                    state_d = ST_WAIT_ADD;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_ADD: begin
                if (cnt_q == LAST_D) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                    grp_d   = '0;
                end
            end
            ST_DRAIN: begin
                // Sample count only moves on accepted cycles.
                cnt_d = out_ready ? cnt_q + 1'b1 : cnt_q;
                if (out_ready && cnt_q == LAST_D) begin
                    cnt_d   = '0;
                    state_d = (grp_q == LAST_G) ? ST_START_CONV : ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_DRAIN;
                cnt_d   = '0;
                grp_d   = grp_q + 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                grp_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            grp_q        <= '0;
            init_q       <= 1'b0;
            start_conv_q <= 1'b0;
            busy_q       <= 1'b0;
            write_zero_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grp_q        <= grp_d;
            init_q       <= (state_q == ST_INIT_BUFF);
            start_conv_q <= (state_q == ST_START_CONV);
            busy_q       <= (state_d != ST_IDLE);
            write_zero_q <= row_ready_w;
        end
    end

    conv_wb_port_mux #(
        .DATA_W    (DATA_W),
        .NUM_ROWS  (NUM_ROWS),
        .NUM_PORTS (NUM_PORTS)
    ) u_port_mux (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_data_i  (row_data),
        .row_valid_i (row_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .err_mux_o   (err_mux)
    );

    assign row_ready  = row_ready_w;
    assign write_zero = write_zero_q;
    assign init       = init_q;
    assign start_conv = start_conv_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_conv_writeback_ctrl.sv
module tb_conv_writeback_ctrl;

    localparam int DW    = 25;
    localparam int DEPTH = 4;
    localparam int NR    = 5;
    localparam int NP    = 2;
    localparam int CT    = 3;
    localparam int NG    = (NR + NP - 1) / NP;
    localparam int MAXC  = 160;
    localparam int NVEC  = 15;

    logic                  clk;
    logic                  rst_n;
    logic                  start_init;
    logic                  filter_end;
    logic [NR*DW-1:0]      row_data;
    logic [NR-1:0]         row_valid;
    logic [NR-1:0]         row_ready;
    logic [NR-1:0]         write_zero;
    logic                  init;
    logic                  start_conv;
    logic [NP*DW-1:0]      out_data;
    logic [NP-1:0]         out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  err_mux;

    int n_pass  = 0;
    int n_total = 0;

    conv_writeback_ctrl #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .NUM_ROWS  (NR),
        .NUM_PORTS (NP),
        .CONV_TAIL (CT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_init (start_init),
        .filter_end (filter_end),
        .row_data   (row_data),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .write_zero (write_zero),
        .init       (init),
        .start_conv (start_conv),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .err_mux    (err_mux)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0]    rv;
        logic [NR*DW-1:0] rd;
        logic             rdy;
        logic [NP*DW-1:0] od;
        logic [NP-1:0]    ov;
        logic             err;
    } mux_vec_t;

    mux_vec_t tbl [NVEC];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NR*DW-1:0] rows5(input logic [DW-1:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    function automatic logic [NP*DW-1:0] ports2(input logic [DW-1:0] a, b);
        return {b, a};
    endfunction

    // Rows lo..hi-1 of group g, as a contiguous bit range.
    function automatic logic [NR-1:0] gmask(input int g);
        int lo, hi;
        logic [31:0] m;
        lo = g * NP;
        hi = (g + 1) * NP;
        if (hi > NR) hi = NR;
        m = (32'd1 << hi) - (32'd1 << lo);
        return m[NR-1:0];
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_write_zero"}, 64'(write_zero), 64'd0);
        chk({tag, "_init"},       64'(init),       64'd0);
        chk({tag, "_start_conv"}, 64'(start_conv), 64'd0);
        chk({tag, "_busy"},       64'(busy),       64'd0);
        chk({tag, "_out_data"},   64'(out_data),   64'd0);
        chk({tag, "_out_valid"},  64'(out_valid),  64'd0);
        chk({tag, "_err_mux"},    64'(err_mux),    64'd0);
        chk({tag, "_row_ready"},  64'(row_ready),  64'd0);
    endtask

    // Frame start from IDLE: init on cycles 2..5, start_conv on 6..12.
    task automatic do_init();
        chk("idle_busy", 64'(busy), 64'd0);
        start_init = 1'b1;
        out_ready  = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            start_init = 1'b0;
            chk("init_flag",  64'(init),       64'(c >= 2 && c <= 5));
            chk("init_sc",    64'(start_conv), 64'(c >= 6 && c <= 12));
            chk("init_wz",    64'(write_zero), 64'd0);
            if (c >= 2) chk("init_busy", 64'(busy), 64'd1);
        end
    endtask

    // One row band from WAIT_FILTER. mode 0: always ready, 1: 3-cycle stall in
    // group 0, 2: random ready plus ignored start_init/filter_end noise.
    task automatic run_band(input int mode);
        logic          rdy_a [MAXC];
        logic [NR-1:0] wz_e  [MAXC];
        logic [NR-1:0] rr_e  [MAXC];
        logic          sc_e  [MAXC];
        int c, acc, fin;
        for (int i = 0; i < MAXC; i++) begin
            rdy_a[i] = (mode == 2 && i < 100) ? ($urandom_range(0, 3) != 0) : 1'b1;
            wz_e[i]  = '0;
            rr_e[i]  = '0;
            sc_e[i]  = 1'b0;
        end
        if (mode == 1) begin
            rdy_a[DEPTH + 3] = 1'b0;
            rdy_a[DEPTH + 4] = 1'b0;
            rdy_a[DEPTH + 5] = 1'b0;
        end
        // Timeline: filter_end at 0, DEPTH add cycles, then each group needs
        // DEPTH accepted cycles, one gap between groups, then conv restarts.
        c = DEPTH + 1;
        for (int g = 0; g < NG; g++) begin
            acc = 0;
            while (acc < DEPTH) begin
                if (rdy_a[c]) begin
                    rr_e[c]     = gmask(g);
                    wz_e[c + 1] = gmask(g);
                    acc++;
                end
                c++;
            end
            if (g != NG - 1) c++;
        end
        fin = c;
        for (int i = fin + 1; i <= fin + DEPTH + CT; i++) sc_e[i] = 1'b1;
        for (c = 0; c <= fin + DEPTH + CT + 1; c++) begin
            filter_end = (c == 0) ||
                         (mode == 2 && c <= fin + DEPTH + CT - 1 && $urandom_range(0, 4) == 0);
            start_init = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready  = rdy_a[c];
            chk("band_write_zero", 64'(write_zero), 64'(wz_e[c]));
            chk("band_start_conv", 64'(start_conv), 64'(sc_e[c]));
            chk("band_busy",       64'(busy),       64'd1);
            #1;
            chk("band_row_ready",  64'(row_ready),  64'(rr_e[c]));
            tick();
        end
        filter_end = 1'b0;
        start_init = 1'b0;
        out_ready  = 1'b1;
    endtask

    logic [NP*DW-1:0] md, nd;
    logic [NP-1:0]    mv, nv;
    logic             me;
    logic             hit;
    logic [127:0]     rnd;

    initial begin
        tbl[0]  = '{5'b00011, rows5(25'h11, 25'h22, 25'h33, 25'h44, 25'h55), 1'b1, ports2(25'h11, 25'h22), 2'b11, 1'b0};
        tbl[1]  = '{5'b01100, rows5(25'h5, 25'h6, 25'h1, 25'h2, 25'h8), 1'b1, ports2(25'h1, 25'h2), 2'b11, 1'b0};
        tbl[2]  = '{5'b10000, rows5(25'h3, 25'h3, 25'h3, 25'h3, 25'h7), 1'b1, ports2(25'h7, 25'h0), 2'b01, 1'b0};
        tbl[3]  = '{5'b00101, rows5(25'h1, 25'h2, 25'h3, 25'h4, 25'h5), 1'b1, ports2(25'h0, 25'h0), 2'b00, 1'b1};
        tbl[4]  = '{5'b00000, rows5(25'h1, 25'h2, 25'h3, 25'h4, 25'h5), 1'b1, ports2(25'h0, 25'h0), 2'b00, 1'b0};
        tbl[5]  = '{5'b00011, rows5(25'h5, 25'h6, 25'h7, 25'h8, 25'h9), 1'b0, ports2(25'h5, 25'h6), 2'b11, 1'b0};
        tbl[6]  = '{5'b01100, rows5(25'h9, 25'h9, 25'h9, 25'h9, 25'h9), 1'b0, ports2(25'h5, 25'h6), 2'b11, 1'b0};
        tbl[7]  = '{5'b00101, rows5(25'h0, 25'h0, 25'h0, 25'h0, 25'h0), 1'b0, ports2(25'h5, 25'h6), 2'b11, 1'b0};
        tbl[8]  = '{5'b01100, rows5(25'h1, 25'h2, 25'h1ABCDEF, 25'h1000001, 25'h4), 1'b1, ports2(25'h1ABCDEF, 25'h1000001), 2'b11, 1'b0};
        tbl[9]  = '{5'b11111, rows5(25'h1, 25'h2, 25'h3, 25'h4, 25'h5), 1'b1, ports2(25'h0, 25'h0), 2'b00, 1'b1};
        tbl[10] = '{5'b11000, rows5(25'h1, 25'h2, 25'h3, 25'h4, 25'h5), 1'b1, ports2(25'h0, 25'h0), 2'b00, 1'b1};
        tbl[11] = '{5'b00000, rows5(25'h1, 25'h2, 25'h3, 25'h4, 25'h5), 1'b0, ports2(25'h0, 25'h0), 2'b00, 1'b0};
        tbl[12] = '{5'b10000, rows5(25'h1, 25'h2, 25'h3, 25'h4, 25'h1FFFFFF), 1'b0, ports2(25'h1FFFFFF, 25'h0), 2'b01, 1'b0};
        tbl[13] = '{5'b00011, rows5(25'h4, 25'h5, 25'h3, 25'h4, 25'h5), 1'b0, ports2(25'h1FFFFFF, 25'h0), 2'b01, 1'b0};
        tbl[14] = '{5'b00011, rows5(25'h4, 25'h5, 25'h3, 25'h4, 25'h5), 1'b1, ports2(25'h4, 25'h5), 2'b11, 1'b0};

        rst_n      = 1'b0;
        start_init = 1'b0;
        filter_end = 1'b0;
        row_data   = '0;
        row_valid  = '0;
        out_ready  = 1'b1;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Mux vectors (controller idle; the mux is state-independent).
        for (int i = 0; i < NVEC; i++) begin
            row_valid = tbl[i].rv;
            row_data  = tbl[i].rd;
            out_ready = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d_out_data", i),  64'(out_data),  64'(tbl[i].od));
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
            chk($sformatf("vec%0d_err_mux", i),   64'(err_mux),   64'(tbl[i].err));
        end

        // Random mux traffic against the rule-level model.
        md = tbl[NVEC-1].od;
        mv = tbl[NVEC-1].ov;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: row_valid = gmask(int'($urandom_range(0, NG - 1)));
                3:       row_valid = '0;
                default: row_valid = NR'($urandom);
            endcase
            rnd       = {$urandom, $urandom, $urandom, $urandom};
            row_data  = rnd[NR*DW-1:0];
            out_ready = 1'($urandom_range(0, 1));
            nd = '0;
            nv = '0;
            me = 1'b0;
            if (mv != '0 && !out_ready) begin
                nd = md;
                nv = mv;
            end else begin
                hit = 1'b0;
                for (int g = 0; g < NG; g++) begin
                    if (row_valid == gmask(g)) begin
                        hit = 1'b1;
                        for (int p = 0; p < NP; p++) begin
                            if (g * NP + p < NR) begin
                                nd[p*DW +: DW] = row_data[(g*NP+p)*DW +: DW];
                                nv[p] = 1'b1;
                            end
                        end
                    end
                end
                me = !hit && row_valid != '0;
            end
            md = nd;
            mv = nv;
            tick();
            chk("rnd_out_data",  64'(out_data),  64'(md));
            chk("rnd_out_valid", 64'(out_valid), 64'(mv));
            chk("rnd_err_mux",   64'(err_mux),   64'(me));
        end
        row_valid = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("mux_drained", 64'(out_valid), 64'd0);

        do_init();
        run_band(0);
        run_band(1);
        run_band(2);
        run_band(2);
        run_band(0);

        // Reset in the middle of draining group 0 with valid data on the ports.
        filter_end = 1'b1;
        tick();
        filter_end = 1'b0;
        row_valid  = 5'b00011;
        row_data   = rows5(25'hA, 25'hB, 25'hC, 25'hD, 25'hE);
        repeat (DEPTH + 2) tick();
        chk("pre_rst_write_zero", 64'(write_zero), 64'(5'b00011));
        chk("pre_rst_out_valid",  64'(out_valid),  64'(2'b11));
        chk("pre_rst_busy",       64'(busy),       64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        rst_n     = 1'b1;
        row_valid = '0;
        tick();
        do_init();
        run_band(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
